ssd_scan_capture: RTL and testbench
===================================

# ssd_scan_capture

Receive-side monitor for the multiplexed seven-segment bus (`pattern[7:0]` segments, `SSD[3:0]` digit enables) driven by the display controller. It watches the scanned bus and identifies which digit is active. It waits for the lines to settle, decodes each glyph back to a hex code, and commits a digit only after it reads the same glyph on consecutive scans. The result is a registered four-digit readback for self-check logic and for the simulation scoreboard. It runs on the same fast clock as the display scan.

## Interface
- `SETTLE`, default 4: cycles `SSD` must hold unchanged before `pattern` is sampled; legal range 1..255.
- `STABLE_SCANS`, default 2: consecutive identical samples of one digit required before commit; legal range 1..15.
- `clk`  in  1  single clock; all state is updated on the rising edge.
- `reset`  in  1  synchronous, active-high; one clock and a synchronous active-high reset, fixed.
- `pattern`  in  8  active-low segments, `{dp,g,f,e,d,c,b,a}` = bits `[7:0]`.
- `SSD`  in  4  active-low one-hot digit enable; `SSD[i]=0` selects digit `i`.
- `digits`  out  16  committed hex codes, digit `i` in `[4i+3:4i]`.
- `dp`  out  4  committed decimal-point state per digit; 1 means lit.
- `digit_valid`  out  4  bit `i` is set once digit `i` has committed at least once.
- `blank`  out  4  committed glyph was all segments off (`pattern[6:0]=7'h7F`).
- `unknown`  out  4  committed glyph was not in the decode table.
- `update`  out  1  one-cycle pulse when any commit changes `digits`, `dp`, `blank` or `unknown`.
- `bus_error`  out  1  one-cycle pulse when a dwell has more than one `SSD` bit low.

## Operation
- **Dwell tracking**
  - `SSD` is registered each cycle.
  - Any difference between `SSD` and its registered value starts a new dwell: the settle counter clears to 0 and the `sampled` flag clears.
- **Sampling**
  - While `SSD` is unchanged, the settle counter increments, saturating at `SETTLE`.
  - The sample fires on the cycle the counter equals `SETTLE` and `sampled` is 0. `sampled` then sets, so there is at most one sample per dwell.
- **Dwell classes**
  - Exactly one bit low: the digit index is decoded and the sample proceeds.
  - `4'b1111` (all off): ignored, no sample, no error.
  - Two or more bits low: `bus_error` pulses once at the sample point, and no sample is taken.
- **Glyph decode** on `pattern[6:0]`, value → code (`blank` and `unknown` are 0 unless stated):
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19, 5 = 12, 6 = 02, 7 = 78
  - 8 = 00, 9 = 10, A = 08, b = 03, C = 46, d = 21, E = 06, F = 0E
  - 7F → code 0, `blank`=1.
  - Any other value → code 0, `unknown`=1.
  - `dp` = `~pattern[7]`.
- **Per-digit candidate:** {code, dp, blank, unknown} plus a 4-bit match count.
  - Sample equals the candidate: count increments, saturating at 15.
  - Sample differs: the candidate is replaced and count is set to 1.
  - Commit happens on the sample where count reaches `STABLE_SCANS` (reaches it, not exceeds it). With `STABLE_SCANS=1`, every changed sample commits immediately.
- **Commit**
  - Writes the digit's slice of `digits`/`dp`/`blank`/`unknown` and sets `digit_valid[i]`.
  - `update` pulses only if the written value differs from the previously committed value or `digit_valid[i]` was 0.
  - Other digits are unaffected.

## Timing
- Reset: all outputs and all internal state are 0. Reset asserted mid-dwell discards candidates, counts and the settle state.
- After reset, the first `SSD` value is treated as a new dwell.
- Sample latency: a digit selected at cycle T with stable inputs is sampled at T+`SETTLE`+1 (one cycle of input register plus `SETTLE` cycles).
- Commit outputs and the `update` pulse appear on the cycle after the qualifying sample.
- A dwell shorter than `SETTLE`+1 cycles produces no sample.
- Changes on `pattern` while `SSD` is stable do not restart the dwell; the value present at the sample cycle is used.
- `SSD` changing on the same cycle as the sample point: the change wins, and no sample is taken.
- `bus_error` and `update` never pulse for more than one cycle per event. They may assert on the same cycle only for different dwells, which cannot happen, so they are mutually exclusive.

## Test plan
- **Nominal readback.** `SETTLE=4`, `STABLE_SCANS=2`. Scan digits 0..3 showing 1,2,3,4, 8 cycles per dwell, 2 full scans. Required: `digits=16'h4321`, `digit_valid=4'hF`, four `update` pulses during scan 2, none during scan 1.
- **Glitch rejection.** Digit 2 shows 5, then one scan shows 6, then 5 again. Required: `digits[11:8]` stays 5 and `update` never pulses. Four consecutive scans of 6 then commit 6 with one `update`.
- **Short dwell.** Digit 0 is selected for 4 cycles (below `SETTLE`+1) on every scan. Required: `digit_valid[0]` stays 0.
- **Blank, unknown and dp.** Digit 1 `pattern=8'hFF`, then `8'h55`, then `8'h40`, each held for 3 scans. Required, in order:
  - `blank[1]=1`
  - then `unknown[1]=1`, code 0
  - then code 0, `dp[1]=1`, `blank[1]`=`unknown[1]`=0.
- **Bus fault.** `SSD=4'b1100` for 10 cycles. Required: exactly one `bus_error` pulse, at cycle 5 after the change, and `digits` unchanged. `SSD=4'b1111` produces no pulse.
- **Reset mid-run.** Assert `reset` for 1 cycle after `digits=16'h4321`. Required: all outputs 0 on the next cycle, and 2 further full scans are needed before `digit_valid=4'hF` again.

Source files
------------

// File: rtl/ssd_scan_capture.sv
// Purpose: passive monitor of a scanned seven-segment bus; decodes each digit back to hex and commits it once it is stable.
// Latency: sample SETTLE+1 cycles after a digit is selected; commit outputs and update appear on the following cycle.
// Backpressure: none; the monitor only observes the bus, and bus_error is a combinational pulse at the sample point.
module ssd_scan_capture #(
    parameter int SETTLE       = 4,
    parameter int STABLE_SCANS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  pattern,
    input  logic [3:0]  SSD,
    output logic [15:0] digits,
    output logic [3:0]  dp,
    output logic [3:0]  digit_valid,
    output logic [3:0]  blank,
    output logic [3:0]  unknown,
    output logic        update,
    output logic        bus_error
);

    localparam logic [7:0] SETTLE_C = 8'(SETTLE);
    localparam logic [3:0] STABLE_C = 4'(STABLE_SCANS);

    // dwell tracking state
    logic [3:0]       ssd_q;
    logic             started_q;
    logic [7:0]       settle_q, settle_d;
    logic             sampled_q, sampled_d;

    // per-digit candidate and committed state
    logic [3:0][3:0]  cand_code_q, cand_code_d;
    logic [3:0]       cand_dp_q, cand_dp_d;
    logic [3:0]       cand_blank_q, cand_blank_d;
    logic [3:0]       cand_unk_q, cand_unk_d;
    logic [3:0][3:0]  cand_cnt_q, cand_cnt_d;
    logic [3:0][3:0]  digits_q, digits_d;
    logic [3:0]       dp_q, dp_d;
    logic [3:0]       blank_q, blank_d;
    logic [3:0]       unk_q, unk_d;
    logic [3:0]       valid_q, valid_d;
    logic             update_q, update_d;

    logic             new_dwell, at_point, one_low, multi_low, sample_fire;
    logic [1:0]       idx;
    logic [3:0]       s_code;
    logic             s_dp, s_blank, s_unk;
    logic             match, changed;
    logic [3:0]       new_cnt;

    // A change on SSD (or the first cycle out of reset) restarts the settle window.
    always_comb begin
        new_dwell = !started_q || (SSD != ssd_q);
        at_point  = !new_dwell && (settle_q == SETTLE_C) && !sampled_q;
        if (new_dwell) begin
            settle_d = 8'd0;
        end else if (settle_q == SETTLE_C) begin
            settle_d = settle_q;
        end else begin
            settle_d = settle_q + 8'd1;
        end
        sampled_d = !new_dwell && (sampled_q || at_point);
    end

    // Classify the digit enable: one bit low selects a digit, all high is idle, anything else is a fault.
    always_comb begin
        one_low = 1'b1;
        idx     = 2'd0;
        case (SSD)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: one_low = 1'b0;
        endcase
        multi_low   = !one_low && (SSD != 4'b1111);
        sample_fire = at_point && one_low;
    end

    assign bus_error = at_point && multi_low && !reset;

    // Map the active-low glyph back to its hex code.
    always_comb begin
        s_code  = 4'h0;
        s_blank = 1'b0;
        s_unk   = 1'b0;
        s_dp    = ~pattern[7];
        case (pattern[6:0])
            7'h40: s_code = 4'h0;
            7'h79: s_code = 4'h1;
            7'h24: s_code = 4'h2;
            7'h30: s_code = 4'h3;
            7'h19: s_code = 4'h4;
            7'h12: s_code = 4'h5;
            7'h02: s_code = 4'h6;
            7'h78: s_code = 4'h7;
            7'h00: s_code = 4'h8;
            7'h10: s_code = 4'h9;
            7'h08: s_code = 4'hA;
            7'h03: s_code = 4'hB;
            7'h46: s_code = 4'hC;
            7'h21: s_code = 4'hD;
            7'h06: s_code = 4'hE;
            7'h0E: s_code = 4'hF;
            7'h7F: s_blank = 1'b1;
            default: s_unk = 1'b1;
        endcase
    end

    // Track repeat count of the sampled glyph per digit and commit when it reaches the stability threshold.
    always_comb begin
        cand_code_d  = cand_code_q;
        cand_dp_d    = cand_dp_q;
        cand_blank_d = cand_blank_q;
        cand_unk_d   = cand_unk_q;
        cand_cnt_d   = cand_cnt_q;
        digits_d     = digits_q;
        dp_d         = dp_q;
        blank_d      = blank_q;
        unk_d        = unk_q;
        valid_d      = valid_q;
        update_d     = 1'b0;
        match        = 1'b0;
        changed      = 1'b0;
        new_cnt      = 4'd0;
        if (sample_fire) begin
            match = (cand_code_q[idx] == s_code) && (cand_dp_q[idx] == s_dp) &&
                    (cand_blank_q[idx] == s_blank) && (cand_unk_q[idx] == s_unk);
            if (match) begin
                new_cnt = (cand_cnt_q[idx] == 4'hF) ? 4'hF : cand_cnt_q[idx] + 4'd1;
            end else begin
                new_cnt = 4'd1;
            end
            cand_code_d[idx]  = s_code;
            cand_dp_d[idx]    = s_dp;
            cand_blank_d[idx] = s_blank;
            cand_unk_d[idx]   = s_unk;
            cand_cnt_d[idx]   = new_cnt;
            if (new_cnt == STABLE_C) begin
                changed = !valid_q[idx] || (digits_q[idx] != s_code) || (dp_q[idx] != s_dp) ||
                          (blank_q[idx] != s_blank) || (unk_q[idx] != s_unk);
                digits_d[idx] = s_code;
                dp_d[idx]     = s_dp;
                blank_d[idx]  = s_blank;
                unk_d[idx]    = s_unk;
                valid_d[idx]  = 1'b1;
                update_d      = changed;
            end
        end
    end

    // State registers; reset clears everything, including any half-built candidate.
    always_ff @(posedge clk) begin
        if (reset) begin
            ssd_q        <= 4'd0;
            started_q    <= 1'b0;
            settle_q     <= 8'd0;
            sampled_q    <= 1'b0;
            cand_code_q  <= '0;
            cand_dp_q    <= '0;
            cand_blank_q <= '0;
            cand_unk_q   <= '0;
            cand_cnt_q   <= '0;
            digits_q     <= '0;
            dp_q         <= '0;
            blank_q      <= '0;
            unk_q        <= '0;
            valid_q      <= '0;
            update_q     <= 1'b0;
        end else begin
            ssd_q        <= SSD;
            started_q    <= 1'b1;
            settle_q     <= settle_d;
            sampled_q    <= sampled_d;
            cand_code_q  <= cand_code_d;
            cand_dp_q    <= cand_dp_d;
            cand_blank_q <= cand_blank_d;
            cand_unk_q   <= cand_unk_d;
            cand_cnt_q   <= cand_cnt_d;
            digits_q     <= digits_d;
            dp_q         <= dp_d;
            blank_q      <= blank_d;
            unk_q        <= unk_d;
            valid_q      <= valid_d;
            update_q     <= update_d;
        end
    end

    assign digits      = digits_q;
    assign dp          = dp_q;
    assign blank       = blank_q;
    assign unknown     = unk_q;
    assign digit_valid = valid_q;
    assign update      = update_q;

endmodule

// File: tb/tb_ssd_scan_capture.sv
// Purpose: bench for ssd_scan_capture with directed scenarios plus randomized dwells against a dwell-level model.
// Latency: model expects a sample at dwell cycle SETTLE+1 and committed outputs one cycle later.
// Backpressure: not applicable; the bench drives the bus freely.
module tb_ssd_scan_capture;

    localparam int SETTLE = 4;
    localparam int STABLE = 2;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic [7:0]  pattern = 8'hFF;
    logic [3:0]  SSD     = 4'hF;
    logic [15:0] digits;
    logic [3:0]  dp, digit_valid, blank, unknown;
    logic        update, bus_error;

    always #5 clk = ~clk;

    ssd_scan_capture #(.SETTLE(SETTLE), .STABLE_SCANS(STABLE)) dut (
        .clk(clk), .reset(reset), .pattern(pattern), .SSD(SSD),
        .digits(digits), .dp(dp), .digit_valid(digit_valid), .blank(blank),
        .unknown(unknown), .update(update), .bus_error(bus_error)
    );

    int checks = 0;
    int errors = 0;

    bit [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // candidate and committed model state per digit
    bit [3:0] c_code [4];
    bit       c_dp [4], c_bl [4], c_un [4];
    int       c_cnt [4];
    bit [3:0] e_code [4];
    bit       e_dp [4], e_bl [4], e_un [4], e_vld [4];
    bit       e_upd = 1'b0;

    int         upd_count = 0;
    int         dwell_berr = 0;
    int         dwell_berr_k = -1;
    logic [3:0] prev_ssd = 4'hF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] gp(input int v, input bit lit);
        return {~lit, glyph[v]};
    endfunction

    function automatic int digit_of(input logic [3:0] s);
        case (s)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            4'b1111: return -1;
            default: return -2;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            c_code[i] = 4'd0; c_dp[i] = 1'b0; c_bl[i] = 1'b0; c_un[i] = 1'b0; c_cnt[i] = 0;
            e_code[i] = 4'd0; e_dp[i] = 1'b0; e_bl[i] = 1'b0; e_un[i] = 1'b0; e_vld[i] = 1'b0;
        end
        e_upd = 1'b0;
    endtask

    task automatic model_sample(input int d, input logic [7:0] p, output bit upd_o);
        bit [3:0] code;
        bit       bl, un, dpv, same, changed;
        code = 4'd0;
        bl   = (p[6:0] == 7'h7F);
        un   = !bl;
        dpv  = !p[7];
        for (int j = 0; j < 16; j++) begin
            if (glyph[j] == p[6:0]) begin
                code = 4'(j);
                un   = 1'b0;
            end
        end
        same = (c_code[d] == code) && (c_dp[d] == dpv) && (c_bl[d] == bl) && (c_un[d] == un);
        if (same) begin
            c_cnt[d] = (c_cnt[d] < 15) ? c_cnt[d] + 1 : 15;
        end else begin
            c_code[d] = code; c_dp[d] = dpv; c_bl[d] = bl; c_un[d] = un;
            c_cnt[d]  = 1;
        end
        upd_o = 1'b0;
        if (c_cnt[d] == STABLE) begin
            changed = !e_vld[d] || (e_code[d] != code) || (e_dp[d] != dpv) ||
                      (e_bl[d] != bl) || (e_un[d] != un);
            e_code[d] = code; e_dp[d] = dpv; e_bl[d] = bl; e_un[d] = un; e_vld[d] = 1'b1;
            upd_o = changed;
        end
    endtask

    task automatic check_outputs(input bit exp_be);
        logic [15:0] ed;
        logic [3:0]  edp, ev, eb, eu;
        for (int i = 0; i < 4; i++) begin
            ed[4*i +: 4] = e_code[i];
            edp[i] = e_dp[i];
            ev[i]  = e_vld[i];
            eb[i]  = e_bl[i];
            eu[i]  = e_un[i];
        end
        chk("digits", 32'(digits), 32'(ed));
        chk("dp", 32'(dp), 32'(edp));
        chk("digit_valid", 32'(digit_valid), 32'(ev));
        chk("blank", 32'(blank), 32'(eb));
        chk("unknown", 32'(unknown), 32'(eu));
        chk("update", 32'(update), 32'(e_upd));
        chk("bus_error", 32'(bus_error), 32'(exp_be));
    endtask

    // One dwell of len cycles on SSD value s; with jitter the pattern wanders after the first cycle.
    task automatic run_dwell(input logic [3:0] s, input logic [7:0] p, input int len, input bit jitter);
        int d;
        bit nxt;
        d = digit_of(s);
        dwell_berr = 0;
        dwell_berr_k = -1;
        for (int k = 0; k < len; k++) begin
            @(posedge clk); #1;
            reset = 1'b0;
            SSD   = s;
            if (k == 0 || !jitter) pattern = p;
            else if ($urandom_range(0, 3) == 0) pattern = 8'($urandom);
            @(negedge clk);
            check_outputs((k == SETTLE + 1) && (d == -2));
            if (bus_error) begin
                dwell_berr++;
                dwell_berr_k = k;
            end
            if (update) upd_count++;
            nxt = 1'b0;
            if (k == SETTLE + 1 && d >= 0) model_sample(d, pattern, nxt);
            e_upd = nxt;
        end
        prev_ssd = s;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_valid", 32'(digit_valid), 32'h0);
        chk("rst_dp", 32'(dp), 32'h0);
        chk("rst_blank", 32'(blank), 32'h0);
        chk("rst_unknown", 32'(unknown), 32'h0);
        chk("rst_update", 32'(update), 32'h0);
        chk("rst_bus_error", 32'(bus_error), 32'h0);
    endtask

    task automatic scan4(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                         input logic [7:0] p3, input int len0);
        run_dwell(4'b1110, p0, len0, 1'b0);
        run_dwell(4'b1101, p1, 8, 1'b0);
        run_dwell(4'b1011, p2, 8, 1'b0);
        run_dwell(4'b0111, p3, 8, 1'b0);
    endtask

    function automatic logic [7:0] rand_pat();
        case ($urandom_range(0, 5))
            0:       return gp(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            1:       return 8'hFF;
            2:       return 8'($urandom);
            default: return gp(int'($urandom_range(0, 1)), 1'b0);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed running expected finished");
        $fatal(1);
    end

    initial begin
        int u;
        logic [15:0] dsave;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_digits", 32'(digits), 32'h0);
        chk("reset_valid", 32'(digit_valid), 32'h0);
        chk("reset_flags", 32'({dp, blank, unknown}), 32'h0);
        chk("reset_pulses", 32'({update, bus_error}), 32'h0);

        // nominal readback
        u = upd_count;
        scan4(gp(1, 0), gp(2, 0), gp(3, 0), gp(4, 0), 8);
        chk("scan1_updates", 32'(upd_count - u), 32'd0);
        u = upd_count;
        scan4(gp(1, 0), gp(2, 0), gp(3, 0), gp(4, 0), 8);
        chk("scan2_updates", 32'(upd_count - u), 32'd4);
        chk("nominal_digits", 32'(digits), 32'h4321);
        chk("nominal_valid", 32'(digit_valid), 32'hF);

        // reset mid-run needs two full scans again
        do_reset();
        scan4(gp(1, 0), gp(2, 0), gp(3, 0), gp(4, 0), 8);
        chk("rst_scan1_valid", 32'(digit_valid), 32'h0);
        scan4(gp(1, 0), gp(2, 0), gp(3, 0), gp(4, 0), 8);
        chk("rst_scan2_valid", 32'(digit_valid), 32'hF);
        chk("rst_scan2_digits", 32'(digits), 32'h4321);

        // glitch rejection on digit 2
        scan4(gp(1, 0), gp(2, 0), gp(5, 0), gp(4, 0), 8);
        scan4(gp(1, 0), gp(2, 0), gp(5, 0), gp(4, 0), 8);
        chk("glitch_base", 32'(digits[11:8]), 32'h5);
        u = upd_count;
        scan4(gp(1, 0), gp(2, 0), gp(6, 0), gp(4, 0), 8);
        scan4(gp(1, 0), gp(2, 0), gp(5, 0), gp(4, 0), 8);
        scan4(gp(1, 0), gp(2, 0), gp(5, 0), gp(4, 0), 8);
        chk("glitch_updates", 32'(upd_count - u), 32'd0);
        chk("glitch_hold", 32'(digits[11:8]), 32'h5);
        u = upd_count;
        for (int n = 0; n < 4; n++) scan4(gp(1, 0), gp(2, 0), gp(6, 0), gp(4, 0), 8);
        chk("six_updates", 32'(upd_count - u), 32'd1);
        chk("six_commit", 32'(digits[11:8]), 32'h6);

        // short dwell on digit 0
        do_reset();
        for (int n = 0; n < 3; n++) scan4(gp(1, 0), gp(2, 0), gp(3, 0), gp(4, 0), SETTLE);
        chk("short_valid", 32'(digit_valid), 32'hE);

        // blank, unknown, decimal point on digit 1
        for (int n = 0; n < 3; n++) scan4(gp(1, 0), 8'hFF, gp(3, 0), gp(4, 0), 8);
        chk("blank_flags", 32'({blank[1], unknown[1], digits[7:4]}), 32'h20);
        for (int n = 0; n < 3; n++) scan4(gp(1, 0), 8'h55, gp(3, 0), gp(4, 0), 8);
        chk("unknown_flags", 32'({blank[1], unknown[1], digits[7:4]}), 32'h10);
        for (int n = 0; n < 3; n++) scan4(gp(1, 0), 8'h40, gp(3, 0), gp(4, 0), 8);
        chk("dp_flags", 32'({dp[1], blank[1], unknown[1], digits[7:4]}), 32'h40);

        // bus fault and idle
        dsave = digits;
        run_dwell(4'b1100, gp(7, 0), 10, 1'b0);
        chk("fault_pulses", 32'(dwell_berr), 32'd1);
        chk("fault_cycle", 32'(dwell_berr_k), 32'(SETTLE + 1));
        chk("fault_digits", 32'(digits), 32'(dsave));
        run_dwell(4'b1111, gp(7, 0), 10, 1'b0);
        chk("idle_pulses", 32'(dwell_berr), 32'd0);

        // randomized dwells
        for (int n = 0; n < 300; n++) begin
            logic [3:0] s;
            int         r;
            if ($urandom_range(0, 39) == 0) do_reset();
            do begin
                r = int'($urandom_range(0, 9));
                if (r < 6) s = 4'hF ^ 4'(4'b0001 << $urandom_range(0, 3));
                else if (r == 6) s = 4'hF;
                else s = 4'($urandom);
            end while (s == prev_ssd);
            run_dwell(s, rand_pat(), int'($urandom_range(1, 12)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
